// File: rtl/tcdm_bank_arb.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_bank_arb
// Description : Bank-side round-robin arbiter for the TCDM crossbar; routes
//               the fixed-latency bank response back to the granted master.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_bank_arb #(
    parameter int unsigned NumIn         = 8,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned RespLat       = 1,
    parameter int unsigned WriteRespOn   = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumIn-1:0]                       req_i,
    input  logic [NumIn-1:0]                       wen_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]     data_i,
    output logic [NumIn-1:0]                       gnt_o,
    output logic [NumIn-1:0]                       vld_o,
    output logic [RespDataWidth-1:0]               rdata_o,
    output logic                                   req_o,
    output logic                                   wen_o,
    output logic [ReqDataWidth-1:0]                data_o,
    input  logic                                   gnt_i,
    input  logic [RespDataWidth-1:0]               rdata_i
);

    localparam int unsigned c_idx_w = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned c_sum_w = c_idx_w + 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(NumIn - 1);

    logic [c_idx_w-1:0] w_ptr;
    logic [c_idx_w-1:0] w_win;
    logic [c_idx_w-1:0] w_idx_last;
    logic [c_sum_w-1:0] w_cand;
    logic               w_found;
    logic               w_hs;
    logic               w_resp;
    logic [RespLat-1:0] r_v;

    // Scan from the pointer upward with wrap; defaults to the pointer when idle.
    always_comb begin
        w_win   = w_ptr;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            w_cand = {1'b0, w_ptr} + c_sum_w'(i);
            if (w_cand >= c_sum_w'(NumIn)) begin
                w_cand = w_cand - c_sum_w'(NumIn);
            end
            if (!w_found && req_i[w_cand[c_idx_w-1:0]]) begin
                w_win   = w_cand[c_idx_w-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign req_o   = |req_i;
    assign wen_o   = wen_i[w_win];
    assign data_o  = data_i[w_win];
    assign rdata_o = rdata_i;
    assign w_hs    = req_o & gnt_i;
    assign w_resp  = w_hs & (~wen_o | (WriteRespOn != 0));

    always_comb begin
        gnt_o        = '0;
        gnt_o[w_win] = w_hs;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v <= '0;
        end else begin
            r_v[0] <= w_resp;
            for (int k = 1; k < int'(RespLat); k++) begin
                r_v[k] <= r_v[k-1];
            end
        end
    end

    generate
        if (NumIn > 1) begin : g_multi
            logic [c_idx_w-1:0]              r_ptr;
            logic [RespLat-1:0][c_idx_w-1:0] r_idx;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_ptr <= '0;
                end else if (w_hs) begin
                    r_ptr <= (w_win == c_last) ? '0 : w_win + c_idx_w'(1);
                end
            end

            // Winner index travels alongside the valid bit to steer the response.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_idx <= '0;
                end else begin
                    r_idx[0] <= w_win;
                    for (int k = 1; k < int'(RespLat); k++) begin
                        r_idx[k] <= r_idx[k-1];
                    end
                end
            end

            assign w_ptr      = r_ptr;
            assign w_idx_last = r_idx[RespLat-1];
        end else begin : g_single
            assign w_ptr      = '0;
            assign w_idx_last = '0;
        end
    endgenerate

    always_comb begin
        vld_o             = '0;
        vld_o[w_idx_last] = r_v[RespLat-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcdm_bank_arb
// Description : Directed scoreboard bench for tcdm_bank_arb, two configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_bank_arb;

    typedef struct {
        int due;
        int idx;
    } exp_t;

    logic clk;
    logic rst_ni;
    int   cyc;
    int   checks;
    int   errors;
    exp_t qa[$];
    exp_t qb[$];

    // Instance A: 5 masters, latency 3, reads only respond
    logic [4:0]        a_req, a_wen, a_gnt_o, a_vld;
    logic [4:0][31:0]  a_data;
    logic [31:0]       a_rdata, a_rdata_o, a_data_o;
    logic              a_req_o, a_wen_o, a_gnt;

    // Instance B: 4 masters, latency 1, writes also respond
    logic [3:0]        b_req, b_wen, b_gnt_o, b_vld;
    logic [3:0][31:0]  b_data;
    logic [31:0]       b_rdata, b_rdata_o, b_data_o;
    logic              b_req_o, b_wen_o, b_gnt;

    tcdm_bank_arb #(.NumIn(5), .ReqDataWidth(32), .RespDataWidth(32),
                    .RespLat(3), .WriteRespOn(0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(a_req), .wen_i(a_wen), .data_i(a_data),
        .gnt_o(a_gnt_o), .vld_o(a_vld), .rdata_o(a_rdata_o), .req_o(a_req_o),
        .wen_o(a_wen_o), .data_o(a_data_o), .gnt_i(a_gnt), .rdata_i(a_rdata)
    );

    tcdm_bank_arb #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32),
                    .RespLat(1), .WriteRespOn(1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(b_req), .wen_i(b_wen), .data_i(b_data),
        .gnt_o(b_gnt_o), .vld_o(b_vld), .rdata_o(b_rdata_o), .req_o(b_req_o),
        .wen_o(b_wen_o), .data_o(b_data_o), .gnt_i(b_gnt), .rdata_i(b_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitors: every cycle the valid vector must match the queue head or be zero.
    always @(negedge clk) begin
        logic [4:0] exp_a;
        logic [3:0] exp_b;
        exp_a = '0;
        exp_b = '0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            exp_a[qa[0].idx] = 1'b1;
            void'(qa.pop_front());
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            exp_b[qb[0].idx] = 1'b1;
            void'(qb.pop_front());
        end
        check("vld_a", 64'(a_vld), 64'(exp_a));
        check("vld_b", 64'(b_vld), 64'(exp_b));
    end

    task automatic step_a(input logic [4:0] req, input logic [4:0] wen, input logic gnt, input int w);
        @(posedge clk);
        #1;
        a_req   = req;
        a_wen   = wen;
        a_gnt   = gnt;
        a_rdata = $urandom;
        @(negedge clk);
        check("a_req_o", 64'(a_req_o), 64'(req != 5'd0));
        check("a_gnt_o", 64'(a_gnt_o), (gnt && req != 5'd0) ? (64'(1) << w) : 64'(0));
        check("a_data_o", 64'(a_data_o), 64'(32'hA000_0000 + w));
        if (req != 5'd0) check("a_wen_o", 64'(a_wen_o), 64'(wen[w]));
        check("a_rdata_o", 64'(a_rdata_o), 64'(a_rdata));
        if (gnt && req != 5'd0 && !wen[w]) qa.push_back('{cyc + 3, w});
    endtask

    task automatic step_b(input logic [3:0] req, input logic [3:0] wen, input logic gnt, input int w);
        @(posedge clk);
        #1;
        b_req   = req;
        b_wen   = wen;
        b_gnt   = gnt;
        b_rdata = $urandom;
        @(negedge clk);
        check("b_req_o", 64'(b_req_o), 64'(req != 4'd0));
        check("b_gnt_o", 64'(b_gnt_o), (gnt && req != 4'd0) ? (64'(1) << w) : 64'(0));
        check("b_data_o", 64'(b_data_o), 64'(32'hB000_0000 + w));
        if (req != 4'd0) check("b_wen_o", 64'(b_wen_o), 64'(wen[w]));
        check("b_rdata_o", 64'(b_rdata_o), 64'(b_rdata));
        if (gnt && req != 4'd0) qb.push_back('{cyc + 1, w});
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_ni = 1'b1;
        a_req = '0; a_wen = '0; a_gnt = 1'b0; a_rdata = '0;
        b_req = '0; b_wen = '0; b_gnt = 1'b0; b_rdata = '0;
        for (int k = 0; k < 5; k++) a_data[k] = 32'hA000_0000 + k;
        for (int k = 0; k < 4; k++) b_data[k] = 32'hB000_0000 + k;
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // ---- Instance A ----
        step_a(5'b11111, 5'b0, 1'b0, 0);        // reset pointer, stalled
        step_a(5'b11111, 5'b0, 1'b1, 0);        // ptr -> 1
        step_a(5'b00100, 5'b0, 1'b1, 2);        // ptr -> 3
        step_a(5'b00010, 5'b0, 1'b1, 1);        // wrap past 4,0; ptr -> 2
        repeat (3) step_a(5'b01100, 5'b0, 1'b0, 2);
        step_a(5'b01100, 5'b0, 1'b1, 2);        // ptr -> 3
        step_a(5'b01000, 5'b0, 1'b1, 3);        // ptr -> 4
        step_a(5'b00010, 5'b0, 1'b1, 1);        // wrap from 4; ptr -> 2
        step_a(5'b00010, 5'b00010, 1'b1, 1);    // write: no response
        step_a(5'b01000, 5'b0, 1'b1, 3);        // ptr -> 4
        for (int i = 0; i < 6; i++) step_a(5'b11111, 5'b0, 1'b1, (4 + i) % 5);
        step_a(5'b00000, 5'b0, 1'b1, 0);        // idle, ptr holds 0
        step_a(5'b11111, 5'b0, 1'b1, 0);
        step_a(5'b11111, 5'b0, 1'b1, 1);
        step_a(5'b11111, 5'b0, 1'b1, 2);

        // Mid-operation reset with responses in flight
        @(posedge clk);
        #1;
        check("a_vld_before_rst", 64'(a_vld), 64'(5'b00001));
        rst_ni = 1'b0;
        a_req  = '0;
        a_gnt  = 1'b0;
        qa.delete();
        #1;
        check("a_vld_async_rst", 64'(a_vld), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        step_a(5'b00000, 5'b0, 1'b0, 0);
        step_a(5'b00000, 5'b0, 1'b0, 0);
        step_a(5'b11111, 5'b0, 1'b1, 0);        // restart at index 0
        repeat (4) step_a(5'b00000, 5'b0, 1'b0, 1);

        // ---- Instance B ----
        for (int i = 0; i < 5; i++) step_b(4'b1111, 4'b0, 1'b1, i % 4);
        step_b(4'b0010, 4'b0010, 1'b1, 1);      // write responds; ptr -> 2
        step_b(4'b1000, 4'b0000, 1'b1, 3);      // ptr -> 0
        step_b(4'b0010, 4'b0000, 1'b1, 1);      // ptr -> 2
        repeat (3) step_b(4'b1100, 4'b0, 1'b0, 2);
        step_b(4'b1100, 4'b0, 1'b1, 2);         // ptr -> 3
        step_b(4'b0011, 4'b0, 1'b1, 0);         // wrap to lowest requester
        repeat (3) step_b(4'b0000, 4'b0, 1'b0, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("qa_drained", 64'(qa.size()), 64'(0));
        check("qb_drained", 64'(qb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
